xalu_md: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage beside the ALU.
- Feeds the XALUOut_E path of the E/M pipeline register.
- Exposes `busy` so the hazard unit can stall D while a result is pending.
- Generalises the fixed 32-bit datapath: operand width and per-op latencies are parameters, and ops can be aborted.

---
 rtl/xalu_pkg.sv | 24 ++
 rtl/xalu_div_core.sv | 24 ++
 rtl/xalu_md.sv | 114 +++++++++++
 tb/tb_xalu_md.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/xalu_pkg.sv
// xalu_pkg: op encodings, op-class helpers and state encodings for xalu_md
package xalu_pkg;
    localparam logic [2:0] XOP_MULT  = 3'd0;
    localparam logic [2:0] XOP_MULTU = 3'd1;
    localparam logic [2:0] XOP_DIV   = 3'd2;
    localparam logic [2:0] XOP_DIVU  = 3'd3;
    localparam logic [2:0] XOP_MTHI  = 3'd4;
    localparam logic [2:0] XOP_MTLO  = 3'd5;
    localparam logic [2:0] XOP_MADD  = 3'd6;
    localparam logic [2:0] XOP_MSUB  = 3'd7;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    // How the pending result is applied to {hi,lo} on completion
    typedef enum logic [1:0] {PM_WR, PM_SKIP, PM_ADD, PM_SUB} pmode_t;

    function automatic logic is_mult(input logic [2:0] op);
        return op == XOP_MULT || op == XOP_MULTU;
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return op == XOP_DIV || op == XOP_DIVU;
    endfunction
endpackage

// File: rtl/xalu_div_core.sv
// xalu_div_core: combinational signed/unsigned divide with zero-divisor guard
module xalu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] ua, ub, uq, ur;

    assign neg_a = sgn & a[WIDTH-1];
    assign neg_b = sgn & b[WIDTH-1];
    assign ua    = neg_a ? -a : a;
    // A zero divisor is replaced by 1; the caller discards that result anyway.
    // MIN/-1 falls out naturally: |MIN| / 1 negated wraps back to MIN, rem 0.
    assign ub    = b == '0 ? WIDTH'(1) : (neg_b ? -b : b);
    assign uq    = ua / ub;
    assign ur    = ua % ub;
    assign q     = (neg_a ^ neg_b) ? -uq : uq;
    assign r     = neg_a ? -ur : ur;
endmodule

// File: rtl/xalu_md.sv
// xalu_md: multi-cycle multiply/divide unit with HI/LO; MADD/MSUB when XALU_MADD_EN is defined
module xalu_md
    import xalu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CMAX = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    state_t             state, state_n;
    pmode_t             pmode, pmode_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [WIDTH-1:0]   hi_n, lo_n, pend_hi, pend_lo, pend_hi_n, pend_lo_n;
    logic [WIDTH-1:0]   quo, rem;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, done_val;
    logic               is_macc, msgn, take;

`ifdef XALU_MADD_EN
    assign is_macc  = op == XOP_MADD || op == XOP_MSUB;
    // Accumulation reads {hi,lo} at completion, not at start
    assign done_val = pmode == PM_ADD ? {hi, lo} + {pend_hi, pend_lo} :
                      pmode == PM_SUB ? {hi, lo} - {pend_hi, pend_lo} : {pend_hi, pend_lo};
`else
    assign is_macc  = 1'b0;
    assign done_val = {pend_hi, pend_lo};
`endif

    // One 2W-bit multiplier serves both signednesses via operand extension
    assign msgn  = op == XOP_MULT || is_macc;
    assign ext_a = {{WIDTH{msgn & a[WIDTH-1]}}, a};
    assign ext_b = {{WIDTH{msgn & b[WIDTH-1]}}, b};
    assign prod  = ext_a * ext_b;
    assign take  = state == ST_IDLE && start && !kill;
    assign busy  = state == ST_RUN;

    xalu_div_core #(.WIDTH(WIDTH)) u_div (
        .a   (a),
        .b   (b),
        .sgn (op == XOP_DIV),
        .q   (quo),
        .r   (rem)
    );

    // Next-state: accept requests in IDLE, count down and retire in RUN
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hi_n      = hi;
        lo_n      = lo;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        pmode_n   = pmode;
        if (state == ST_IDLE) begin
            if (take && op == XOP_MTHI) hi_n = a;
            if (take && op == XOP_MTLO) lo_n = a;
            if (take && (is_mult(op) || is_macc)) begin
                state_n                = ST_RUN;
                cnt_n                  = CW'(MULT_CYCLES);
                {pend_hi_n, pend_lo_n} = prod;
                pmode_n                = op == XOP_MADD ? PM_ADD : op == XOP_MSUB ? PM_SUB : PM_WR;
            end
            if (take && is_div(op)) begin
                state_n   = ST_RUN;
                cnt_n     = CW'(DIV_CYCLES);
                pend_hi_n = rem;
                pend_lo_n = quo;
                pmode_n   = b == '0 ? PM_SKIP : PM_WR;
            end
        end else if (kill) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else if (cnt == CW'(1)) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            if (pmode != PM_SKIP) {hi_n, lo_n} = done_val;
        end else begin
            cnt_n = cnt - CW'(1);
        end
    end

    // State and register update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pmode   <= PM_WR;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            hi      <= hi_n;
            lo      <= lo_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
            pmode   <= pmode_n;
        end
    end
endmodule

// File: tb/tb_xalu_md.sv
// tb_xalu_md: randomized and directed bench for xalu_md with a behavioural HI/LO model
module tb_xalu_md;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        kill = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;
    int          elat = 0;

    xalu_md dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .kill  (kill),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sp, sq, sr;
        logic [63:0] up;
        elat = 0;
        case (o)
            3'd0: begin sp = longint'($signed(x)) * longint'($signed(y)); {mhi, mlo} = sp; elat = 5; end
            3'd1: begin up = {32'd0, x} * {32'd0, y}; {mhi, mlo} = up; elat = 5; end
            3'd2: begin
                elat = 10;
                if (y != 0) begin
                    sq  = longint'($signed(x)) / longint'($signed(y));
                    sr  = longint'($signed(x)) % longint'($signed(y));
                    mlo = sq[31:0];
                    mhi = sr[31:0];
                end
            end
            3'd3: begin
                elat = 10;
                if (y != 0) begin
                    mlo = x / y;
                    mhi = x % y;
                end
            end
            3'd4: mhi = x;
            3'd5: mlo = x;
            default: begin
`ifdef XALU_MADD_EN
                sp = longint'($signed(x)) * longint'($signed(y));
                {mhi, mlo} = o == 3'd6 ? {mhi, mlo} + sp : {mhi, mlo} - sp;
                elat = 5;
`endif
            end
        endcase
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string nm);
        int n = 0;
        model(o, x, y);
        issue(o, x, y);
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== elat) begin errors++; $display("FAIL %s latency got %0d exp %0d", nm, n, elat); end
        checks++;
        if (hi !== mhi) begin errors++; $display("FAIL %s hi got %h exp %h", nm, hi, mhi); end
        checks++;
        if (lo !== mlo) begin errors++; $display("FAIL %s lo got %h exp %h", nm, lo, mlo); end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL reset busy/hi/lo got %b/%h/%h exp 0/0/0", busy, hi, lo);
        end
        mhi = '0; mlo = '0;
        reset = 1'b1;
    endtask

    logic [2:0]  d_op [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd4, 3'd5, 3'd2};
    logic [31:0] d_a  [8] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'h11, 32'h22, 32'd5};
    logic [31:0] d_b  [8] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
    logic [31:0] d_hi [8] = '{32'hFFFFFFFF, 32'd6, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h11, 32'h11, 32'h11};
    logic [31:0] d_lo [8] = '{32'hFFFFFFEB, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd3, 32'h80000000, 32'h80000000, 32'h22, 32'h22};

    task automatic test_directed;
        for (int i = 0; i < 8; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], $sformatf("directed%0d", i));
            checks++;
            if (hi !== d_hi[i] || lo !== d_lo[i]) begin
                errors++; $display("FAIL directed%0d_const hi/lo got %h/%h exp %h/%h", i, hi, lo, d_hi[i], d_lo[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) y = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
            run_op(o, x, y, $sformatf("random%0d_op%0d", i, o));
        end
    endtask

    task automatic test_back_to_back;
        run_op(3'd0, 32'd123, 32'hFFFFFF00, "b2b_mult");
        run_op(3'd3, 32'd1000, 32'd7, "b2b_divu");
        run_op(3'd5, 32'hA5A5A5A5, 32'd0, "b2b_mtlo");
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "b2b_multu");
    endtask

    task automatic test_busy_ignore;
        int n = 0;
        model(3'd0, 32'd6, 32'd7);
        issue(3'd0, 32'd6, 32'd7);
        start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd3;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (n !== 5) begin errors++; $display("FAIL busy_ignore latency got %0d exp 5", n); end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd42) begin errors++; $display("FAIL busy_ignore hi/lo got %h/%h exp 0/2a", hi, lo); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignore late_start busy got %b exp 0", busy); end
    endtask

    task automatic test_kill;
        issue(3'd0, $urandom, $urandom);
        repeat (2) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== mhi || lo !== mlo) begin
            errors++; $display("FAIL kill_mid busy/hi/lo got %b/%h/%h exp 0/%h/%h", busy, hi, lo, mhi, mlo);
        end
        issue(3'd1, $urandom, $urandom);
        repeat (4) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== mhi || lo !== mlo) begin
            errors++; $display("FAIL kill_last busy/hi/lo got %b/%h/%h exp 0/%h/%h", busy, hi, lo, mhi, mlo);
        end
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = mlo ^ 32'h5A5A0001; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || lo !== mlo) begin
            errors++; $display("FAIL kill_idle busy/lo got %b/%h exp 0/%h", busy, lo, mlo);
        end
        run_op(3'd3, 32'd100, 32'd7, "after_kill_divu");
    endtask

    task automatic test_reset_mid;
        issue(3'd0, 32'd11, 32'd13);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mhi = '0; mlo = '0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL reset_mid busy/hi/lo got %b/%h/%h exp 0/0/0", busy, hi, lo);
        end
        run_op(3'd5, 32'd5, 32'd0, "reset_mid_mtlo");
        checks++;
        if (lo !== 32'd5) begin errors++; $display("FAIL reset_mid_mtlo_const lo got %h exp 5", lo); end
    endtask

    task automatic test_madd;
`ifdef XALU_MADD_EN
        run_op(3'd4, 32'd0, 32'd0, "madd_mthi");
        run_op(3'd5, 32'd10, 32'd0, "madd_mtlo");
        run_op(3'd6, 32'd3, 32'd4, "madd");
        checks++;
        if (hi !== 32'd0 || lo !== 32'd22) begin errors++; $display("FAIL madd_const hi/lo got %h/%h exp 0/16", hi, lo); end
        run_op(3'd7, 32'd5, 32'd5, "msub");
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL msub_const hi/lo got %h/%h exp ffffffff/fffffffd", hi, lo);
        end
`else
        run_op(3'd6, 32'd3, 32'd4, "op6_ignored");
        run_op(3'd7, 32'd5, 32'd5, "op7_ignored");
`endif
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_busy_ignore;
        test_kill;
        test_reset_mid;
        test_madd;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
